// File: rtl/mac4_pkg.sv
// Shared types, widths and arithmetic helpers for the MAC4 result collector.
// Saturation helper is used only when MAC4_COLLECT_SAT_EN is defined.
package mac4_pkg;

   localparam int MAC4_IN_W  = 18;
   localparam int MAC4_ACC_W = 32;

   typedef logic signed [MAC4_IN_W-1:0]  psum_t;
   typedef logic signed [MAC4_ACC_W-1:0] acc_t;

   // Add two already sign-extended values and clip to a w-bit signed range.
   function automatic logic signed [63:0] sat_add(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 w
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi)
         return hi;
      else if (s < lo)
         return lo;
      else
         return s;
   endfunction

endpackage

// File: rtl/mac4_result_collector_if.sv
// Partial-sum input stream and ready/valid result stream of the collector.
// slave: collector side; master: producer/consumer side.
interface mac4_result_collector_if
   import mac4_pkg::*;
#(
   parameter int IN_W  = MAC4_IN_W,
   parameter int ACC_W = MAC4_ACC_W
);

   logic                    valid_in;
   logic signed [IN_W-1:0]  c_in;
   logic                    res_valid;
   logic                    res_ready;
   logic signed [ACC_W-1:0] res_data;

   modport slave (
      input  valid_in,
      input  c_in,
      input  res_ready,
      output res_valid,
      output res_data
   );

   modport master (
      output valid_in,
      output c_in,
      output res_ready,
      input  res_valid,
      input  res_data
   );

endinterface

// File: rtl/mac4_result_fifo.sv
// First-word-fall-through result FIFO with synchronous flush.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module mac4_result_fifo
   import mac4_pkg::*;
#(
   parameter int W     = MAC4_ACC_W,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are masked on the output while empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mac4_result_collector.sv
// Accumulates CHUNKS MAC partial sums per result and queues results.
// Define MAC4_COLLECT_SAT_EN for saturating accumulation and sat_o.
module mac4_result_collector
   import mac4_pkg::*;
#(
   parameter int IN_W       = MAC4_IN_W,
   parameter int ACC_W      = MAC4_ACC_W,
   parameter int CHUNKS     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   mac4_result_collector_if.slave bus,
   output logic [15:0]            chunk_cnt,
   output logic                   drop_o,
   output logic                   sat_o
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] ext;
   logic signed [ACC_W-1:0] sum;
   logic                    last;
   logic                    push;
   logic                    pop;
   logic                    full;
   logic                    empty;

   assign base = (chunk_cnt == 16'd0) ? '0 : acc;
   assign ext  = ACC_W'(bus.c_in);
   assign last = (chunk_cnt == 16'(CHUNKS - 1));
   assign push = bus.valid_in && !clr && last;
   assign pop  = bus.res_ready && !clr;

`ifdef MAC4_COLLECT_SAT_EN
   logic signed [63:0] wide;
   logic signed [63:0] clip;
   logic               clamp;

   assign wide  = 64'(base) + 64'(ext);
   assign clip  = sat_add(64'(base), 64'(ext), ACC_W);
   assign clamp = (clip != wide);
   assign sum   = clip[ACC_W-1:0];

   // Sticky record of any clamp applied to an accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_o <= 1'b0;
      else if (clr)
         sat_o <= 1'b0;
      else if (bus.valid_in && clamp)
         sat_o <= 1'b1;
   end
`else
   assign sum   = base + ext;
   assign sat_o = 1'b0;
`endif

   // Beat counter, running sum and sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         chunk_cnt <= '0;
         drop_o    <= 1'b0;
      end else if (clr) begin
         acc       <= '0;
         chunk_cnt <= '0;
         drop_o    <= 1'b0;
      end else begin
         if (bus.valid_in) begin
            if (last) begin
               chunk_cnt <= '0;
            end else begin
               acc       <= sum;
               chunk_cnt <= chunk_cnt + 16'd1;
            end
         end
         if (push && full && !bus.res_ready)
            drop_o <= 1'b1;
      end
   end

   mac4_result_fifo #(
      .W     (ACC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (clr),
      .push  (push),
      .pop   (pop),
      .din   (sum),
      .dout  (bus.res_data),
      .full  (full),
      .empty (empty)
   );

   assign bus.res_valid = !empty;

endmodule
